// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

   localparam int unsigned SCAN_CYCLES_DEF     = 100000;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_e;

   // Indexed [row][column]; values are what the seven-segment decoder shows.
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   function automatic logic [1:0] first_low_row(input logic [3:0] pat);
      first_low_row = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!pat[i]) first_low_row = 2'(i);
      end
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value is the idle level.
module sync_2ff #(
   parameter int unsigned      WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: non-blocking assignments so both flops sample the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad controller with press/release debouncing.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES     = SCAN_CYCLES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       rs;
   state_e           state_q, state_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;

   sync_2ff #(
      .WIDTH     (4),
      .RESET_VAL (4'hF)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (row),
      .q_o (rs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         col_idx_q   <= 2'd0;
         pat_q       <= 4'hF;
         cnt_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         pat_q       <= pat_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no latches.
   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      unique case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (rs != 4'hF) begin
                  pat_d   = rs;
                  state_d = ST_DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DEBOUNCE: begin
            if (rs != pat_q) begin
               state_d   = ST_SCAN;
               col_idx_d = col_idx_q + 2'd1;
               cnt_d     = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = ST_PRESSED;
               cnt_d       = '0;
               key_code_d  = KEY_MAP[first_low_row(pat_q)][col_idx_q];
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_PRESSED: begin
            if (rs == 4'hF) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end
         end

         ST_RELEASE: begin
            // Any renewed contact drops back to PRESSED without a new pulse.
            if (rs != 4'hF) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d    = ST_SCAN;
               col_idx_d  = 2'd0;
               cnt_d      = '0;
               key_held_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = ST_SCAN;
      endcase
   end

   assign col       = ~(4'b0001 << col_idx_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad contact model, directed tables and randomized presses.
module tb_keypad_scanner;

   localparam int SC = 4;
   localparam int DC = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   // key_rows[c][r] = 1 means the switch at row r, column c is closed.
   logic [3:0] key_rows [4];

   int checks = 0;
   int errors = 0;

   int         pulses = 0;
   logic [3:0] pulse_codes [$];
   int         col_bad = 0;
   int         valid_long = 0;
   logic       prev_valid = 1'b0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_CYCLES     (SC),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Passive matrix: a row reads low when a closed switch ties it to a driven-low column.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (!col[c]) row = row & ~key_rows[c];
      end
   end

   always @(negedge clk) begin
      if (key_valid) begin
         pulses <= pulses + 1;
         pulse_codes.push_back(key_code);
      end
      if (key_valid && prev_valid) valid_long <= valid_long + 1;
      prev_valid <= key_valid;
      if (!(col inside {4'hE, 4'hD, 4'hB, 4'h7})) col_bad <= col_bad + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic release_all();
      for (int c = 0; c < 4; c++) key_rows[c] = 4'h0;
   endtask

   task automatic wait_pulse(input int max_cycles, output bit seen, output int waited);
      int start;
      start  = pulses;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < max_cycles) begin
         step(1);
         waited++;
         if (pulses != start) seen = 1'b1;
      end
   endtask

   task automatic wait_held_low(input int max_cycles, output bit seen);
      int waited;
      waited = 0;
      seen   = !key_held;
      while (!seen && waited < max_cycles) begin
         step(1);
         waited++;
         if (!key_held) seen = 1'b1;
      end
   endtask

   function automatic logic [3:0] last_code();
      if (pulse_codes.size() == 0) return 4'hx;
      return pulse_codes[pulse_codes.size() - 1];
   endfunction

   // Reference key decode from the printed keypad legend.
   function automatic logic [3:0] model_code(input logic [3:0] rows, input int c);
      string legend;
      int    r;
      byte   ch;
      legend = "123A456B789C0FED";
      r = 0;
      while (r < 3 && !rows[r]) r++;
      ch = legend[r * 4 + c];
      if (ch >= 8'h30 && ch <= 8'h39) return 4'(ch - 8'h30);
      return 4'(ch - 8'h41 + 10);
   endfunction

   typedef struct {
      logic [3:0] rows;
      int         cidx;
      logic [3:0] code;
   } vec_t;

   vec_t vecs [$];

   initial begin
      bit seen;
      int waited;
      int base;
      int held_low;

      vecs = '{
         '{4'b0001, 0, 4'h1}, '{4'b0001, 1, 4'h2}, '{4'b0001, 2, 4'h3}, '{4'b0001, 3, 4'hA},
         '{4'b0010, 0, 4'h4}, '{4'b0010, 1, 4'h5}, '{4'b0010, 2, 4'h6}, '{4'b0010, 3, 4'hB},
         '{4'b0100, 0, 4'h7}, '{4'b0100, 1, 4'h8}, '{4'b0100, 2, 4'h9}, '{4'b0100, 3, 4'hC},
         '{4'b1000, 0, 4'h0}, '{4'b1000, 1, 4'hF}, '{4'b1000, 2, 4'hE}, '{4'b1000, 3, 4'hD},
         '{4'b0101, 0, 4'h1}, '{4'b1010, 3, 4'hB}, '{4'b1100, 1, 4'h8}, '{4'b1111, 2, 4'h3}
      };

      release_all();
      rst = 1'b1;
      step(3);
      check("reset_col", col, 4'hE);
      check("reset_code", key_code, 4'h0);
      check("reset_valid", key_valid, 1'b0);
      check("reset_held", key_held, 1'b0);
      rst = 1'b0;

      // Column rotation, four cycles per column.
      step(3);
      check("rot_dwell_col0", col, 4'hE);
      step(1);
      check("rot_col1", col, 4'hD);
      step(4);
      check("rot_col2", col, 4'hB);
      step(4);
      check("rot_col3", col, 4'h7);
      step(4);
      check("rot_wrap_col0", col, 4'hE);

      // Key '6': row1 closed on column 2 only.
      pulse_codes.delete();
      base = pulses;
      key_rows[2] = 4'b0010;
      wait_pulse(100, seen, waited);
      check("k6_pulse_seen", seen, 1'b1);
      step(30);
      check("k6_pulse_count", pulses - base, 1);
      check("k6_pulse_code", last_code(), 4'h6);
      check("k6_code_out", key_code, 4'h6);
      check("k6_held", key_held, 1'b1);
      check("k6_col_frozen", col, 4'hB);
      key_rows[2] = 4'b0000;
      step(10);
      check("k6_held_before_release_done", key_held, 1'b1);
      step(1);
      check("k6_held_dropped", key_held, 1'b0);
      check("k6_col_restart", col, 4'hE);

      // Bouncing contact at column 0: never stable long enough.
      base = pulses;
      for (int i = 0; i < 40; i++) begin
         key_rows[0][0] = ((i / 3) % 2) == 0;
         step(1);
      end
      release_all();
      step(40);
      check("bounce_no_pulse", pulses - base, 0);
      check("bounce_code_kept", key_code, 4'h6);
      check("bounce_not_held", key_held, 1'b0);

      // Full key map and multi-row priority.
      foreach (vecs[i]) begin
         pulse_codes.delete();
         base = pulses;
         key_rows[vecs[i].cidx] = vecs[i].rows;
         wait_pulse(100, seen, waited);
         check($sformatf("tbl%0d_pulse_seen", i), seen, 1'b1);
         step(20);
         check($sformatf("tbl%0d_code", i), last_code(), vecs[i].code);
         check($sformatf("tbl%0d_one_pulse", i), pulses - base, 1);
         check($sformatf("tbl%0d_held", i), key_held, 1'b1);
         release_all();
         wait_held_low(40, seen);
         check($sformatf("tbl%0d_released", i), seen, 1'b1);
         step(5);
      end

      // Key '0' held for 1000 cycles.
      pulse_codes.delete();
      base = pulses;
      key_rows[0] = 4'b1000;
      wait_pulse(100, seen, waited);
      check("k0_pulse_seen", seen, 1'b1);
      check("k0_code", last_code(), 4'h0);
      held_low = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (!key_held) held_low++;
      end
      check("k0_held_throughout", held_low, 0);
      check("k0_single_pulse", pulses - base, 1);
      release_all();
      wait_held_low(40, seen);
      check("k0_released", seen, 1'b1);
      step(5);

      // Reset while pressed, key kept down: cleared, then a fresh debounce.
      pulse_codes.delete();
      key_rows[1] = 4'b0010;
      wait_pulse(100, seen, waited);
      check("rstp_first_pulse", seen, 1'b1);
      step(5);
      rst = 1'b1;
      step(1);
      check("rstp_code_clr", key_code, 4'h0);
      check("rstp_valid_clr", key_valid, 1'b0);
      check("rstp_held_clr", key_held, 1'b0);
      check("rstp_col", col, 4'hE);
      rst = 1'b0;
      base = pulses;
      wait_pulse(100, seen, waited);
      check("rstp_fresh_pulse", seen, 1'b1);
      check("rstp_fresh_debounce_time", waited >= DC, 1'b1);
      check("rstp_fresh_code", last_code(), 4'h5);
      step(10);
      check("rstp_one_pulse", pulses - base, 1);
      check("rstp_held", key_held, 1'b1);
      release_all();
      wait_held_low(40, seen);
      check("rstp_released", seen, 1'b1);

      // Reset during debounce abandons the press.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      key_rows[0] = 4'b0001;
      base = pulses;
      step(6);
      rst = 1'b1;
      step(1);
      check("rstd_col", col, 4'hE);
      release_all();
      rst = 1'b0;
      step(60);
      check("rstd_no_pulse", pulses - base, 0);

      // Randomized presses, some preceded by a short glitch.
      for (int n = 0; n < 24; n++) begin
         int         c;
         logic [3:0] rows;
         c    = $urandom_range(0, 3);
         rows = 4'($urandom_range(1, 15));
         pulse_codes.delete();
         base = pulses;
         if ($urandom_range(0, 1) == 1) begin
            key_rows[$urandom_range(0, 3)] = 4'($urandom_range(1, 15));
            step($urandom_range(1, 5));
            release_all();
            step(12);
         end
         key_rows[c] = rows;
         step($urandom_range(40, 70));
         check($sformatf("rnd%0d_held", n), key_held, 1'b1);
         release_all();
         step($urandom_range(30, 50));
         check($sformatf("rnd%0d_pulses", n), pulses - base, 1);
         check($sformatf("rnd%0d_code", n), last_code(), model_code(rows, c));
         check($sformatf("rnd%0d_released", n), key_held, 1'b0);
      end

      check("col_one_cold_always", col_bad, 0);
      check("valid_single_cycle", valid_long, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
